// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline control slice: hazard FSM states,
// register index width and default dmem timeout.
package riscv_pipe_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int MEM_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(
    input logic                 ld,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2
  );
    return ld && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hz_branch_eval.sv
// Taken decision for the control-flow instruction sitting in EX/MEM,
// from its jump/branch-type flags and the ALU zero / signed less-than results.
module hz_branch_eval (
  input  logic jmp_i,
  input  logic beq_i,
  input  logic bneq_i,
  input  logic bge_i,
  input  logic blt_i,
  input  logic zero_i,
  input  logic lt_i,
  output logic taken_o
);

  assign taken_o = jmp_i
                 | (beq_i  &  zero_i)
                 | (bneq_i & ~zero_i)
                 | (blt_i  &  lt_i)
                 | (bge_i  & ~lt_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage RV32 pipeline: dmem wait-state FSM,
// branch/jump redirect, load-use bubble and saturating stall/flush counters.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 idex_mr,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 exmem_jmp,
  input  logic                 exmem_beq,
  input  logic                 exmem_bneq,
  input  logic                 exmem_bge,
  input  logic                 exmem_blt,
  input  logic                 exmem_zero,
  input  logic                 exmem_lt,
  input  logic                 exmem_mr,
  input  logic                 exmem_mw,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 pc_sel_target,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 exmem_hold,
  output logic                 memwb_bubble,
  output logic                 dmem_req,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [1:0]           fsm_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  // Handshake: dmem_req is held high for the whole access; the access retires in
  // the first cycle dmem_ready is sampled high while dmem_req is high.

  hz_state_e         state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic taken;
  logic lu_hit;
  logic req;
  logic in_err;
  logic mem_stall;
  logic active;
  logic redirect;
  logic lu_stall;
  logic hold;
  logic pc_write_int;

  hz_branch_eval u_branch_eval (
    .jmp_i   (exmem_jmp),
    .beq_i   (exmem_beq),
    .bneq_i  (exmem_bneq),
    .bge_i   (exmem_bge),
    .blt_i   (exmem_blt),
    .zero_i  (exmem_zero),
    .lt_i    (exmem_lt),
    .taken_o (taken)
  );

  assign lu_hit = load_use_hit(idex_mr, idex_rd, ifid_rs1, ifid_rs2);

  always_comb begin
    req = 1'b0;
    case (state_q)
      ST_RUN:      req = exmem_mr | exmem_mw;
      ST_MEM_WAIT: req = 1'b1;
      default:     req = 1'b0;
    endcase
    in_err    = (state_q == ST_ERROR);
    mem_stall = req & ~dmem_ready;
    // A memory stall freezes EX/MEM and ID/EX, so redirect and load-use wait for it.
    active       = ~in_err & ~mem_stall;
    redirect     = active & taken;
    lu_stall     = active & ~taken & lu_hit;
    hold         = in_err | mem_stall;
    pc_write_int = ~hold & ~lu_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_q <= ST_ERROR;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_ERROR: state_q <= ST_ERROR;
        default: begin
          state_q <= ST_RUN;
          wait_q  <= '0;
        end
      endcase
      if (!pc_write_int && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1))      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Every output is forced low while reset is held.
  assign pc_write      = ~rst & pc_write_int;
  assign ifid_write    = ~rst & pc_write_int;
  assign pc_sel_target = ~rst & redirect;
  assign ifid_flush    = ~rst & redirect;
  assign idex_flush    = ~rst & (redirect | lu_stall);
  assign exmem_flush   = ~rst & redirect;
  assign exmem_hold    = ~rst & hold;
  assign memwb_bubble  = ~rst & hold;
  assign dmem_req      = ~rst & req;
  assign mem_err       = ~rst & in_err;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for pipe_hazard_ctrl, checked against
// a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int T       = 6;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic idex_mr, exmem_jmp, exmem_beq, exmem_bneq, exmem_bge, exmem_blt;
  logic exmem_zero, exmem_lt, exmem_mr, exmem_mw, dmem_ready;
  logic pc_write, ifid_write, pc_sel_target, ifid_flush, idex_flush, exmem_flush;
  logic exmem_hold, memwb_bubble, dmem_req, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;

  // model state: access in progress, its not-ready cycle count, error, counter totals
  bit m_err, m_wait;
  int m_nr, m_stall, m_flush;
  // expected outputs for the current cycle
  bit e_pcw, e_ifw, e_sel, e_iff, e_idf, e_exf, e_hold, e_bub, e_req, e_err, e_mstall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_mr(idex_mr), .idex_rd(idex_rd),
    .exmem_jmp(exmem_jmp), .exmem_beq(exmem_beq), .exmem_bneq(exmem_bneq),
    .exmem_bge(exmem_bge), .exmem_blt(exmem_blt), .exmem_zero(exmem_zero),
    .exmem_lt(exmem_lt), .exmem_mr(exmem_mr), .exmem_mw(exmem_mw),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .pc_sel_target(pc_sel_target),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_exp();
    bit taken, lu, redir, lus;
    {e_pcw, e_ifw, e_sel, e_iff, e_idf, e_exf, e_hold, e_bub, e_req, e_err, e_mstall} = '0;
    if (!rst) begin
      taken = exmem_jmp || (exmem_beq && exmem_zero) || (exmem_bneq && !exmem_zero)
           || (exmem_blt && exmem_lt) || (exmem_bge && !exmem_lt);
      lu = idex_mr && (idex_rd != 0) && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
      e_req    = !m_err && (m_wait || exmem_mr || exmem_mw);
      e_mstall = e_req && !dmem_ready;
      redir    = !m_err && !e_mstall && taken;
      lus      = !m_err && !e_mstall && !taken && lu;
      e_pcw  = !(m_err || e_mstall || lus);
      e_ifw  = e_pcw;
      e_sel  = redir;
      e_iff  = redir;
      e_idf  = redir || lus;
      e_exf  = redir;
      e_hold = m_err || e_mstall;
      e_bub  = e_hold;
      e_err  = m_err;
    end
  endtask

  task automatic check_all(input string tag);
    compute_exp();
    chk({tag, ".pc_write"},      pc_write,      e_pcw);
    chk({tag, ".ifid_write"},    ifid_write,    e_ifw);
    chk({tag, ".pc_sel_target"}, pc_sel_target, e_sel);
    chk({tag, ".ifid_flush"},    ifid_flush,    e_iff);
    chk({tag, ".idex_flush"},    idex_flush,    e_idf);
    chk({tag, ".exmem_flush"},   exmem_flush,   e_exf);
    chk({tag, ".exmem_hold"},    exmem_hold,    e_hold);
    chk({tag, ".memwb_bubble"},  memwb_bubble,  e_bub);
    chk({tag, ".dmem_req"},      dmem_req,      e_req);
    chk({tag, ".mem_err"},       mem_err,       e_err);
    chk({tag, ".stall_cnt"},     32'(stall_cnt), rst ? 0 : m_stall);
    chk({tag, ".flush_cnt"},     32'(flush_cnt), rst ? 0 : m_flush);
  endtask

  // one clock: check at negedge, advance model at posedge, return just after it
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (!m_err) begin
      if (e_mstall) begin
        if (m_wait && m_nr == T) m_err = 1;
        else begin m_nr++; m_wait = 1; end
      end else if (m_wait) begin
        m_wait = 0;
        m_nr   = 0;
      end
    end
    if (!e_pcw && m_stall < CNT_MAX) m_stall++;
    if (e_sel && m_flush < CNT_MAX) m_flush++;
    #1;
  endtask

  task automatic idle_inputs();
    {ifid_rs1, ifid_rs2, idex_rd} = '0;
    {idex_mr, exmem_jmp, exmem_beq, exmem_bneq, exmem_bge, exmem_blt} = '0;
    {exmem_zero, exmem_lt, exmem_mr, exmem_mw} = '0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    {m_err, m_wait} = '0;
    m_nr = 0; m_stall = 0; m_flush = 0;
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset("reset0");
    cycle("idle");

    // taken beq, then the same branch not taken
    exmem_beq = 1; exmem_zero = 1;
    cycle("beq_taken");
    exmem_beq = 0; exmem_zero = 0;
    cycle("after_beq");
    chk("flush_cnt_one", 32'(flush_cnt), 1);
    exmem_beq = 1; exmem_zero = 0;
    cycle("beq_not_taken");
    exmem_beq = 0;

    // load-use on rs2, then a load into x0
    idex_mr = 1; idex_rd = 7; ifid_rs2 = 7;
    cycle("load_use");
    idex_rd = 0; ifid_rs2 = 0; ifid_rs1 = 0;
    cycle("load_x0");
    idex_mr = 0;

    // three wait states on a load
    do_reset("reset1");
    exmem_mr = 1; dmem_ready = 0;
    repeat (3) cycle("mem_wait3");
    dmem_ready = 1;
    cycle("mem_done");
    exmem_mr = 0;
    cycle("mem_after");
    chk("stall_cnt_three", 32'(stall_cnt), 3);

    // load-use together with a taken jump: the redirect wins
    idex_mr = 1; idex_rd = 3; ifid_rs1 = 3; exmem_jmp = 1;
    cycle("lu_plus_jmp");
    exmem_jmp = 0;
    // memory stall together with load-use: only the memory stall
    exmem_mw = 1; dmem_ready = 0;
    cycle("mem_plus_lu");
    dmem_ready = 1;
    cycle("mem_plus_lu_done");
    idle_inputs();
    cycle("idle2");

    // reset while waiting with five not-ready cycles counted
    exmem_mr = 1; dmem_ready = 0;
    repeat (5) cycle("pre_reset_wait");
    do_reset("reset_mid_wait");
    idle_inputs();
    cycle("post_reset_run");

    // timeout into the sticky error state
    exmem_mr = 1; dmem_ready = 0;
    repeat (T + 1) cycle("to_timeout");
    chk("mem_err_set", mem_err, 1);
    chk("err_no_req", dmem_req, 0);
    dmem_ready = 1; exmem_jmp = 1;
    repeat (3) cycle("error_sticky");
    chk("err_still_stalled", pc_write, 0);
    idle_inputs();

    // randomized traffic, periodic resets, varying memory readiness
    for (int seg = 0; seg < 6; seg++) begin
      do_reset("reset_rand");
      rdy_pct = (seg == 3) ? 2 : 7;
      for (int i = 0; i < 150; i++) begin
        ifid_rs1 = 5'($urandom_range(0, 3));
        ifid_rs2 = 5'($urandom_range(0, 3));
        idex_rd  = 5'($urandom_range(0, 3));
        idex_mr  = 1'($urandom_range(0, 1));
        exmem_mr = ($urandom_range(0, 3) == 0);
        exmem_mw = !exmem_mr && ($urandom_range(0, 5) == 0);
        {exmem_jmp, exmem_beq, exmem_bneq, exmem_bge, exmem_blt} = '0;
        if (!exmem_mr && !exmem_mw) begin
          case ($urandom_range(0, 6))
            0: exmem_jmp  = 1;
            1: exmem_beq  = 1;
            2: exmem_bneq = 1;
            3: exmem_bge  = 1;
            4: exmem_blt  = 1;
            default: ;
          endcase
        end
        exmem_zero = 1'($urandom_range(0, 1));
        exmem_lt   = 1'($urandom_range(0, 1));
        dmem_ready = ($urandom_range(0, 9) < rdy_pct);
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
